// File: rtl/adaptive_bina_pkg.sv
// Shared widths, output codes and small arithmetic helpers for the
// local-mean adaptive binarisation stage.
package adaptive_bina_pkg;

    // Width of the 8-neighbour sum and of the scaled centre+offset term.
    // 8*255 + 8*255 = 4080 still fits, so nothing downstream can wrap.
    localparam int SUM_W = 12;
    // Width of one row partial sum (3*255 = 765).
    localparam int ROW_W = 10;
    // Width of the row/column counters (matches the 12-bit geometry params).
    localparam int CNT_W = 12;

    localparam logic [7:0] PIX_FG = 8'hFF;
    localparam logic [7:0] PIX_BG = 8'h00;

    // Saturating increment: holds at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + CNT_W'(1);
    endfunction

    // Final decision: strict compare of centre term against neighbour sum.
    function automatic logic [7:0] binarise(input logic             kill,
                                            input logic [SUM_W-1:0] lhs,
                                            input logic [SUM_W-1:0] sum8);
        return (!kill && (lhs > sum8)) ? PIX_FG : PIX_BG;
    endfunction

endpackage

// File: rtl/adaptive_bina_linebuf.sv
// Shift RAM of DEPTH bytes: o_dout is the byte written exactly DEPTH
// enabled cycles earlier. Only the write pointer is reset, not the RAM.
module adaptive_bina_linebuf #(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] r_ptr;

    // Read the slot before it is overwritten: that is the oldest entry.
    assign o_dout = r_mem[r_ptr];

    // RAM write on every enabled cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_en) r_mem[r_ptr] <= i_din;
    end

    // Circular pointer advancing only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_ptr <= '0;
        else if (i_en) r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end

endmodule

// File: rtl/adaptive_bina.sv
// Local-mean adaptive binarisation: 3x3 window from two cascaded line
// buffers, centre pixel compared against the mean of its 8 neighbours
// minus OFFSET. Four register stages from gray_* to bina_*.
module adaptive_bina
    import adaptive_bina_pkg::*;
#(
    parameter logic [11:0] H_DISP = 12'd640,
    parameter logic [11:0] V_DISP = 12'd480,
    parameter logic [7:0]  OFFSET = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gray_de,
    input  logic       gray_hsync,
    input  logic       gray_vsync,
    input  logic [7:0] gray_data,
    output logic       bina_de,
    output logic       bina_hsync,
    output logic       bina_vsync,
    output logic [7:0] bina_data
);

    // Control / counters
    logic             r_de_d, r_vs_d, r_armed;
    logic [CNT_W-1:0] r_col_cnt, r_row_cnt;
    logic             w_de_fall, w_vs_rise, w_kill;

    // Sync delay lines
    logic [3:0] r_de_sr, r_hs_sr, r_vs_sr;

    // Line buffer taps
    logic [7:0] w_lb1, w_lb2;

    // Window (stage 1)
    logic [7:0] r_m11, r_m12, r_m13;
    logic [7:0] r_m21, r_m22, r_m23;
    logic [7:0] r_m31, r_m32, r_m33;
    logic       r_kill_p1;

    // Row sums (stage 2)
    logic [ROW_W-1:0] r_s1_p2, r_s2_p2, r_s3_p2;
    logic [7:0]       r_m22_p2;
    logic             r_kill_p2;

    // Totals (stage 3)
    logic [SUM_W-1:0] r_sum8_p3, r_lhs_p3;
    logic             r_kill_p3;

    // Output (stage 4)
    logic [7:0] r_data_p4;

    assign w_de_fall = r_de_d & ~gray_de;
    assign w_vs_rise = gray_vsync & ~r_vs_d;
    // A pixel is suppressed when blanking, before the first vsync after
    // reset, or when its window would reach past the top/left edge.
    assign w_kill = ~gray_de | ~r_armed |
                    (r_row_cnt < CNT_W'(2)) | (r_col_cnt < CNT_W'(2));

    adaptive_bina_linebuf #(.DEPTH(int'(H_DISP))) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (gray_de),
        .i_din  (gray_data),
        .o_dout (w_lb1)
    );

    adaptive_bina_linebuf #(.DEPTH(int'(H_DISP))) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (gray_de),
        .i_din  (w_lb1),
        .o_dout (w_lb2)
    );

    // Edge detectors, frame arming and saturating row/column counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_d    <= 1'b0;
            r_vs_d    <= 1'b0;
            r_armed   <= 1'b0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            r_de_d <= gray_de;
            r_vs_d <= gray_vsync;
            if (w_vs_rise) r_armed <= 1'b1;
            if (gray_de)        r_col_cnt <= sat_inc(r_col_cnt, H_DISP - 12'd1);
            else if (w_de_fall) r_col_cnt <= '0;
            if (w_vs_rise)      r_row_cnt <= '0;
            else if (w_de_fall) r_row_cnt <= sat_inc(r_row_cnt, V_DISP - 12'd1);
        end
    end

    // Sync signals ride a fixed 4-deep delay, independent of the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_sr <= '0;
            r_hs_sr <= '0;
            r_vs_sr <= '0;
        end else begin
            r_de_sr <= {r_de_sr[2:0], gray_de};
            r_hs_sr <= {r_hs_sr[2:0], gray_hsync};
            r_vs_sr <= {r_vs_sr[2:0], gray_vsync};
        end
    end

    // ---- stage 1: window shift (bottom row = live pixel) ----
    // Shift the 3x3 window one column on every enabled pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill_p1 <= 1'b1;
            {r_m11, r_m12, r_m13} <= '0;
            {r_m21, r_m22, r_m23} <= '0;
            {r_m31, r_m32, r_m33} <= '0;
        end else begin
            r_kill_p1 <= w_kill;
            if (gray_de) begin
                r_m11 <= r_m12; r_m12 <= r_m13; r_m13 <= w_lb2;
                r_m21 <= r_m22; r_m22 <= r_m23; r_m23 <= w_lb1;
                r_m31 <= r_m32; r_m32 <= r_m33; r_m33 <= gray_data;
            end
        end
    end

    // ---- stage 2: per-row neighbour sums ----
    // Row partial sums; the centre is excluded from the middle row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_p2   <= '0;
            r_s2_p2   <= '0;
            r_s3_p2   <= '0;
            r_m22_p2  <= '0;
            r_kill_p2 <= 1'b1;
        end else begin
            r_s1_p2   <= ROW_W'(r_m11) + ROW_W'(r_m12) + ROW_W'(r_m13);
            r_s2_p2   <= ROW_W'(r_m21) + ROW_W'(r_m23);
            r_s3_p2   <= ROW_W'(r_m31) + ROW_W'(r_m32) + ROW_W'(r_m33);
            r_m22_p2  <= r_m22;
            r_kill_p2 <= r_kill_p1;
        end
    end

    // ---- stage 3: neighbour total and scaled centre+offset ----
    // Compare 8*(centre+C) with the 8-sum instead of dividing by 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum8_p3 <= '0;
            r_lhs_p3  <= '0;
            r_kill_p3 <= 1'b1;
        end else begin
            r_sum8_p3 <= SUM_W'(r_s1_p2) + SUM_W'(r_s2_p2) + SUM_W'(r_s3_p2);
            r_lhs_p3  <= {1'b0, r_m22_p2, 3'b000} + {1'b0, OFFSET, 3'b000};
            r_kill_p3 <= r_kill_p2;
        end
    end

    // ---- stage 4: threshold decision ----
    // Register the binary result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data_p4 <= '0;
        else     r_data_p4 <= binarise(r_kill_p3, r_lhs_p3, r_sum8_p3);
    end

    assign bina_de    = r_de_sr[3];
    assign bina_hsync = r_hs_sr[3];
    assign bina_vsync = r_vs_sr[3];
    assign bina_data  = r_data_p4;

endmodule
